// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and default widths for the elastic pipeline-stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side plus downstream side.
interface pipe_skid_stage_if #(
    parameter int unsigned DATA_W = pipe_pkg::DEF_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // master is the surrounding pipeline; slave is the stage register itself
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating event counter; holds at all-ones once reached.
module sat_counter #(
    parameter int unsigned CNT_W = pipe_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with 2-entry skid buffer and synchronous flush.
// Optional statistics counters are built when PIPE_SKID_STATS_EN is defined.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ZERO_ON_BUBBLE = 1,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_skid_stage_if.slave bus,
    output logic [1:0]       occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_flush_cnt,
    output logic [CNT_W-1:0] stat_stall_cnt
`endif
);

    occ_e              state;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] s_data;
    logic              ready_q;
    logic              in_accept;
    logic              out_accept;

    assign in_accept  = bus.in_valid & ready_q;
    assign out_accept = bus.out_valid & bus.out_ready;

    // in_ready is a flop tracking !S_valid so out_ready never reaches it combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= OCC_EMPTY;
            m_data  <= '0;
            s_data  <= '0;
            ready_q <= 1'b1;
        end else if (flush) begin
            state   <= OCC_EMPTY;
            m_data  <= '0;
            s_data  <= '0;
            ready_q <= 1'b1;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (in_accept) begin
                        m_data <= bus.in_data;
                        state  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_accept && out_accept) begin
                        m_data <= bus.in_data;
                    end else if (out_accept) begin
                        state <= OCC_EMPTY;
                    end else if (in_accept) begin
                        s_data  <= bus.in_data;
                        state   <= OCC_FULL;
                        ready_q <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (out_accept) begin
                        m_data  <= s_data;
                        state   <= OCC_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= OCC_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = (state != OCC_EMPTY);
    assign bus.out_data  = ((ZERO_ON_BUBBLE != 0) && (state == OCC_EMPTY)) ? '0 : m_data;
    assign occupancy     = state;

`ifdef PIPE_SKID_STATS_EN
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush && (state != OCC_EMPTY)),
        .count (stat_flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.out_valid && !bus.out_ready),
        .count (stat_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage; stats scenarios run when PIPE_SKID_STATS_EN is defined.
module tb_pipe_skid_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [1:0]    occupancy;
    int            checks = 0;
    int            failures = 0;
`ifdef PIPE_SKID_STATS_EN
    logic [CW-1:0] stat_flush_cnt;
    logic [CW-1:0] stat_stall_cnt;
`endif

    pipe_skid_stage_if #(.DATA_W(DW)) bus ();

    pipe_skid_stage #(
        .DATA_W         (DW),
        .ZERO_ON_BUBBLE (1),
        .CNT_W          (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stat_flush_cnt (stat_flush_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 time unit before sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        flush         = f;
    endtask

    // observed vector: {out_valid, in_ready, occupancy, out_data}
    function automatic logic [DW+3:0] obs();
        return {bus.out_valid, bus.in_ready, occupancy, bus.out_data};
    endfunction

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        step();
        if (obs() !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs(), {1'b0, 1'b1, 2'd0, 32'h0});
        end
        checks++;
        reset = 1'b0;
`ifdef PIPE_SKID_STATS_EN
        if ({stat_flush_cnt, stat_stall_cnt} !== 4'h0) begin
            failures++;
            $display("FAIL reset_stats got=%h exp=0", {stat_flush_cnt, stat_stall_cnt});
        end
        checks++;
`endif
    endtask

    task automatic test_single();
        drive(1'b1, 32'hA5, 1'b1, 1'b0);
        step();
        if (obs() !== {1'b1, 1'b1, 2'd1, 32'hA5}) begin
            failures++;
            $display("FAIL single_out got=%h exp=%h", obs(), {1'b1, 1'b1, 2'd1, 32'hA5});
        end
        checks++;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        if (obs() !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL single_drain got=%h exp=%h", obs(), {1'b0, 1'b1, 2'd0, 32'h0});
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            step();
            if (obs() !== {1'b1, 1'b1, 2'd1, DW'(i)}) begin
                failures++;
                $display("FAIL b2b_%0d got=%h exp=%h", i, obs(), {1'b1, 1'b1, 2'd1, DW'(i)});
            end
            checks++;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        if (obs() !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL b2b_drain got=%h exp=%h", obs(), {1'b0, 1'b1, 2'd0, 32'h0});
        end
        checks++;
    endtask

    task automatic test_skid();
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        step();
        if (obs() !== {1'b1, 1'b0, 2'd2, 32'h11}) begin
            failures++;
            $display("FAIL skid_full got=%h exp=%h", obs(), {1'b1, 1'b0, 2'd2, 32'h11});
        end
        checks++;
        // offered while full: must be ignored, output must hold
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        step();
        if (obs() !== {1'b1, 1'b0, 2'd2, 32'h11}) begin
            failures++;
            $display("FAIL skid_hold got=%h exp=%h", obs(), {1'b1, 1'b0, 2'd2, 32'h11});
        end
        checks++;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        if (obs() !== {1'b1, 1'b1, 2'd1, 32'h22}) begin
            failures++;
            $display("FAIL skid_pop1 got=%h exp=%h", obs(), {1'b1, 1'b1, 2'd1, 32'h22});
        end
        checks++;
        step();
        if (obs() !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL skid_pop2 got=%h exp=%h", obs(), {1'b0, 1'b1, 2'd0, 32'h0});
        end
        checks++;
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h55, 1'b0, 1'b1);
        step();
        if (obs() !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL flush_full got=%h exp=%h", obs(), {1'b0, 1'b1, 2'd0, 32'h0});
        end
        checks++;
        // input accepted during a flush from empty is discarded
        drive(1'b1, 32'h66, 1'b1, 1'b1);
        step();
        if (obs() !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL flush_accept got=%h exp=%h", obs(), {1'b0, 1'b1, 2'd0, 32'h0});
        end
        checks++;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        if (obs() !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL flush_after got=%h exp=%h", obs(), {1'b0, 1'b1, 2'd0, 32'h0});
        end
        checks++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        if (obs() !== {1'b1, 1'b1, 2'd1, 32'h77}) begin
            failures++;
            $display("FAIL areset_pre got=%h exp=%h", obs(), {1'b1, 1'b1, 2'd1, 32'h77});
        end
        checks++;
        #2;
        reset = 1'b1;
        #1;
        if (obs() !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL areset_now got=%h exp=%h", obs(), {1'b0, 1'b1, 2'd0, 32'h0});
        end
        checks++;
        reset = 1'b0;
        drive(1'b1, 32'h78, 1'b1, 1'b0);
        step();
        if (obs() !== {1'b1, 1'b1, 2'd1, 32'h78}) begin
            failures++;
            $display("FAIL areset_resume got=%h exp=%h", obs(), {1'b1, 1'b1, 2'd1, 32'h78});
        end
        checks++;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
    endtask

`ifdef PIPE_SKID_STATS_EN
    task automatic test_stats();
        if (stat_stall_cnt !== 2'd0) begin
            failures++;
            $display("FAIL stall_start got=%0d exp=0", stat_stall_cnt);
        end
        checks++;
        drive(1'b1, 32'h81, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        if (stat_stall_cnt !== 2'd3) begin
            failures++;
            $display("FAIL stall_sat got=%0d exp=3", stat_stall_cnt);
        end
        checks++;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b1, 1'b1);
        step();
        if (stat_flush_cnt !== 2'd0) begin
            failures++;
            $display("FAIL flush_empty got=%0d exp=0", stat_flush_cnt);
        end
        checks++;
        drive(1'b1, 32'h82, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        if (stat_flush_cnt !== 2'd1) begin
            failures++;
            $display("FAIL flush_one got=%0d exp=1", stat_flush_cnt);
        end
        checks++;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
    endtask
`endif

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_back_to_back();
        test_skid();
        test_flush();
        test_async_reset();
`ifdef PIPE_SKID_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised elastic pipeline-stage register with valid/ready handshake, a 2-entry skid buffer, and synchronous flush.
- Replaces the fixed per-stage control flops (E->B and similar) between core pipeline stages.
- Supports stall back-pressure without a combinational ready path.
- Flush turns in-flight entries into bubbles whose payload reads as zero, so RegWrite/MemWrite/Branch-type bits cannot fire.

Parameters:
DATA_W, 32, payload width in bits (packed control+data bundle of the stage).
ZERO_ON_BUBBLE, 1, when 1 out_data is forced to 0 whenever out_valid=0; when 0 out_data shows the raw main register.
CNT_W, 16, width of statistics counters (used only with PIPE_SKID_STATS_EN).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous kill of all held entries (branch mispredict / jump redirect).
in_valid  input  1  upstream has a valid payload.
in_ready  output  1  stage can accept; registered output, no combinational path from out_ready.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  main entry valid.
out_ready  input  1  downstream accepts this cycle.
out_data  output  DATA_W  payload to next stage.
occupancy  output  2  entries held: 0, 1 or 2.
stat_flush_cnt  output  CNT_W  (PIPE_SKID_STATS_EN only) flushes that killed >=1 entry.
stat_stall_cnt  output  CNT_W  (PIPE_SKID_STATS_EN only) cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main reg M (data+valid) drives the output; skid reg S (data+valid) holds overflow.
- State from {M_valid, S_valid}: EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) is illegal and never reached.
- in_accept = in_valid & in_ready. out_accept = out_valid & out_ready.
- in_ready is a flop, equal to ~S_valid of the current state. Reset value 1.
- EMPTY: in_accept -> M<=in_data, go ONE. Otherwise stay.
- ONE:
  - in_accept & out_accept -> M<=in_data, stay ONE.
  - out_accept only -> go EMPTY.
  - in_accept only -> S<=in_data, go FULL, in_ready<=0.
  - Neither -> hold.
- FULL: in_ready=0, so input is ignored.
  - out_accept -> M<=S, S invalid, go ONE, in_ready<=1.
  - Otherwise hold.
- Latency: 1 cycle from in_accept to out_valid. Sustained throughput: 1 transfer/cycle.
- Ordering: strict FIFO. Payload is never duplicated or dropped except by flush.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold constant.
- occupancy = M_valid + S_valid.
- out_data = (ZERO_ON_BUBBLE && !M_valid) ? 0 : M_data.
- Flush (synchronous, priority over every handshake):
  - Next state EMPTY; M_data and S_data <= 0; in_ready <= 1.
  - An input accepted in the flush cycle is discarded; upstream still sees the handshake as complete.
  - out_accept in the flush cycle still counts downstream; the entry is consumed, not replayed.
- Reset (asynchronous): M/S valid=0, data=0, in_ready=1, out_valid=0, out_data=0, occupancy=0, stats=0.
  - Reset mid-transfer drops all entries.
  - First accept is possible on the first clock edge after reset deasserts.

Optional Feature:
Macro PIPE_SKID_STATS_EN.
- Defined:
  - stat_flush_cnt increments on each flush cycle with occupancy!=0.
  - stat_stall_cnt increments on each cycle with out_valid & !out_ready.
  - Both saturate at all-ones, reset to 0, and are not cleared by flush.
- Undefined: both stat ports and their logic are absent. Core behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] occ_e {OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2}.
  - Localparams for default DATA_W and CNT_W.
- Sub-module sat_counter (parameter CNT_W; inputs clk, reset, inc; output count).
  - Instantiated twice under PIPE_SKID_STATS_EN.
- The handshake/state logic stays in pipe_skid_stage.

Test Plan:
- Reset, then in_valid=1, in_data=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5; in_ready stays 1.
- Stream 0x1..0x8 back-to-back with out_ready=1 -> 8 outputs on consecutive cycles, in order, no gaps.
- out_ready=0, push 0x11, 0x22 -> occupancy=2, in_ready=0 next cycle, out_data holds 0x11. Then out_ready=1 -> 0x11, then 0x22; in_ready returns to 1.
- FULL with 0x33, 0x44, assert flush with in_valid=1 (0x55) -> next cycle out_valid=0, out_data=0 (ZERO_ON_BUBBLE=1), occupancy=0; 0x55 never appears.
- Assert reset asynchronously mid-stream while occupancy=1 -> outputs zero immediately, before the next clk edge; the stream resumes cleanly after deassert.
- With PIPE_SKID_STATS_EN, CNT_W=2:
  - 5 stall cycles -> stat_stall_cnt=3 (saturated).
  - Flush while empty -> stat_flush_cnt unchanged.
  - Flush while occupancy=1 -> stat_flush_cnt=1.
